// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the pool1 -> conv2 feature-map path.
//   DW      bits per channel sample
//   CH      channels packed into one pixel word
//   IN_DIM  pooled map width/height
//   K       convolution window size
//   OUT_DIM window positions per axis (IN_DIM-K+1)
//   AW      per-bank address width of the frame buffer
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package cnn_pkg;

   localparam int unsigned DW      = 16;
   localparam int unsigned CH      = 6;
   localparam int unsigned IN_DIM  = 12;
   localparam int unsigned K       = 5;
   localparam int unsigned OUT_DIM = IN_DIM - K + 1;
   localparam int unsigned AW      = 8;
   localparam int unsigned PW      = DW * CH;

   // One pooled pixel, channel k in bits [(k+1)*DW-1 : k*DW]
   typedef logic [PW-1:0] pixel_t;

   // Replay side FSM
   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_e;

endpackage : cnn_pkg

// File: rtl/fmap_bank_ram.sv
// ---------------------------------------------------------------------------
// fmap_bank_ram
// Simple dual-port RAM holding both ping-pong banks; the bank select is the
// address MSB. Synchronous read, one cycle latency; rdata holds while re=0.
// Ports:
//   clk           clock
//   we/waddr/wdata write port
//   re/raddr      read request
//   rdata         registered read data
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fmap_bank_ram #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW:0]      waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW:0]      raddr,
   output logic [WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** (AW + 1);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write and registered read
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule : fmap_bank_ram

// File: rtl/pool1_fmap_window_buf.sv
// ---------------------------------------------------------------------------
// pool1_fmap_window_buf
// Captures the pooled IN_DIM x IN_DIM map into a ping-pong buffer and
// replays each frame as KxK window taps (kx fastest, then ky, ox, oy) over a
// valid/ready stream. Capture of the next frame overlaps replay.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_data        pooled pixel word
//   in_valid       one-cycle pixel strobe, raster order, cannot stall
//   out_data       window tap pixel word
//   out_valid      tap available
//   out_ready      consumer accepts
//   out_first      tap (0,0) of a window
//   out_last       tap (K-1,K-1) of a window
//   out_frame_end  last tap of the last window
//   ovf_err        sticky: a pixel arrived while both banks were full
// Build option: define POOL1_BUF_RELU_EN to clamp negative channels to 0 on
// capture; otherwise data is stored bit-exact.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pool1_fmap_window_buf #(
   parameter int unsigned DW     = cnn_pkg::DW,
   parameter int unsigned CH     = cnn_pkg::CH,
   parameter int unsigned IN_DIM = cnn_pkg::IN_DIM,
   parameter int unsigned K      = cnn_pkg::K,
   parameter int unsigned AW     = cnn_pkg::AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DW*CH-1:0] in_data,
   input  logic             in_valid,
   output logic [DW*CH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_first,
   output logic             out_last,
   output logic             out_frame_end,
   output logic             ovf_err
);

   import cnn_pkg::*;

   localparam int unsigned WORD_W  = DW * CH;
   localparam int unsigned OUT_DIM = IN_DIM - K + 1;
   localparam int unsigned NPIX    = IN_DIM * IN_DIM;
   localparam int unsigned CW      = $clog2(IN_DIM);

   // ---------------- write side ----------------
   logic              wbank;
   logic [AW-1:0]     wptr;
   logic [1:0]        full_q;
   logic [1:0]        full_clr;
   logic [1:0]        full_free;
   logic [1:0]        full_n;
   logic              wr_en;
   logic              wr_drop;
   logic              wr_wrap;
   logic [WORD_W-1:0] wr_word;

   // ---------------- read side ----------------
   rd_state_e         state, state_n;
   logic              rd_next, rd_next_n;
   logic [CW-1:0]     kx, ky, ox, oy;
   logic [CW-1:0]     kx_n, ky_n, ox_n, oy_n;
   logic              iss_done, iss_done_n;
   logic              can_issue;
   logic              issue;
   logic              advance;
   logic              release_ok;
   logic              tap_first, tap_last, tap_fend;
   logic [AW-1:0]     rd_addr;
   logic [WORD_W-1:0] rd_data;
   logic              s1_valid, s1_first, s1_last, s1_fend;

   // Output register can take a new word when empty or being drained
   assign advance    = !out_valid || out_ready;
   assign release_ok = out_valid && out_ready && out_frame_end;

   // Bank bookkeeping: a release frees its bank before the write's full check
   always_comb begin
      full_clr = 2'b00;
      if (release_ok) begin
         full_clr[rd_next] = 1'b1;
      end
      full_free = full_q & ~full_clr;
      wr_drop   = in_valid && full_free[wbank];
      wr_en     = in_valid && !full_free[wbank];
      wr_wrap   = wr_en && (wptr == AW'(NPIX - 1));
      full_n    = full_free;
      if (wr_wrap) begin
         full_n[wbank] = 1'b1;
      end
   end

`ifdef POOL1_BUF_RELU_EN
   // Fused ReLU: negative two's-complement channels stored as zero
   always_comb begin
      wr_word = in_data;
      for (int c = 0; c < int'(CH); c++) begin
         if (in_data[c*DW + DW - 1]) begin
            wr_word[c*DW +: DW] = '0;
         end
      end
   end
`else
   assign wr_word = in_data;
`endif

   // Write pointer, bank toggle, full flags, sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbank   <= 1'b0;
         wptr    <= '0;
         full_q  <= 2'b00;
         ovf_err <= 1'b0;
      end else begin
         full_q <= full_n;
         if (wr_en) begin
            if (wr_wrap) begin
               wptr  <= '0;
               wbank <= ~wbank;
            end else begin
               wptr <= wptr + AW'(1);
            end
         end
         if (wr_drop) begin
            ovf_err <= 1'b1;
         end
      end
   end

   // Tap tags and read address for the tap currently being issued
   always_comb begin
      tap_first = (kx == '0) && (ky == '0);
      tap_last  = (kx == CW'(K - 1)) && (ky == CW'(K - 1));
      tap_fend  = tap_last && (ox == CW'(OUT_DIM - 1)) && (oy == CW'(OUT_DIM - 1));
      rd_addr   = AW'((32'(oy) + 32'(ky)) * IN_DIM + 32'(ox) + 32'(kx));
   end

   // Replay FSM next-state and counter sequencing
   always_comb begin
      state_n    = state;
      rd_next_n  = rd_next;
      kx_n       = kx;
      ky_n       = ky;
      ox_n       = ox;
      oy_n       = oy;
      iss_done_n = iss_done;
      can_issue  = 1'b0;

      unique case (state)
         RD_IDLE: begin
            // Counters are already zero here; first tap issues immediately
            if (full_q[rd_next]) begin
               state_n   = RD_STREAM;
               can_issue = 1'b1;
            end
         end
         RD_STREAM: begin
            can_issue = !iss_done;
            if (release_ok) begin
               rd_next_n = !rd_next;
               state_n   = full_q[!rd_next] ? RD_STREAM : RD_IDLE;
            end
         end
         default: state_n = RD_IDLE;
      endcase

      // Issue only when the RAM output stage will not be overwritten
      issue = can_issue && (!s1_valid || advance);

      if (issue) begin
         if (kx == CW'(K - 1)) begin
            kx_n = '0;
            if (ky == CW'(K - 1)) begin
               ky_n = '0;
               if (ox == CW'(OUT_DIM - 1)) begin
                  ox_n = '0;
                  oy_n = (oy == CW'(OUT_DIM - 1)) ? '0 : oy + CW'(1);
               end else begin
                  ox_n = ox + CW'(1);
               end
            end else begin
               ky_n = ky + CW'(1);
            end
         end else begin
            kx_n = kx + CW'(1);
         end
         if (tap_fend) begin
            iss_done_n = 1'b1;
         end
      end

      if (release_ok) begin
         kx_n       = '0;
         ky_n       = '0;
         ox_n       = '0;
         oy_n       = '0;
         iss_done_n = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RD_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Read counters and drain-order bank pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_next  <= 1'b0;
         kx       <= '0;
         ky       <= '0;
         ox       <= '0;
         oy       <= '0;
         iss_done <= 1'b0;
      end else begin
         rd_next  <= rd_next_n;
         kx       <= kx_n;
         ky       <= ky_n;
         ox       <= ox_n;
         oy       <= oy_n;
         iss_done <= iss_done_n;
      end
   end

   // RAM-stage tags and output skid register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_first      <= 1'b0;
         s1_last       <= 1'b0;
         s1_fend       <= 1'b0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_first     <= 1'b0;
         out_last      <= 1'b0;
         out_frame_end <= 1'b0;
      end else begin
         if (issue) begin
            s1_valid <= 1'b1;
            s1_first <= tap_first;
            s1_last  <= tap_last;
            s1_fend  <= tap_fend;
         end else if (advance) begin
            s1_valid <= 1'b0;
         end

         if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data      <= rd_data;
               out_first     <= s1_first;
               out_last      <= s1_last;
               out_frame_end <= s1_fend;
            end else begin
               out_first     <= 1'b0;
               out_last      <= 1'b0;
               out_frame_end <= 1'b0;
            end
         end
      end
   end

   fmap_bank_ram #(
      .WIDTH (WORD_W),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr ({wbank, wptr}),
      .wdata (wr_word),
      .re    (issue),
      .raddr ({rd_next, rd_addr}),
      .rdata (rd_data)
   );

endmodule : pool1_fmap_window_buf

// File: tb/tb_pool1_fmap_window_buf.sv
// ---------------------------------------------------------------------------
// tb_pool1_fmap_window_buf
// Randomised bench for pool1_fmap_window_buf. The reference model keeps the
// captured frames as pixel arrays and expands each complete frame into its
// window-tap sequence with plain nested loops; overflow is modelled by a
// count of stored frames. Honours POOL1_BUF_RELU_EN in the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pool1_fmap_window_buf;

   import cnn_pkg::*;

   localparam int NK   = int'(K);
   localparam int NI   = int'(IN_DIM);
   localparam int NO   = int'(OUT_DIM);
   localparam int NPX  = NI * NI;
   localparam int NBT  = NO * NO * NK * NK;
   localparam int BW   = int'(PW) + 3;

   typedef logic [BW-1:0] beat_t;

   logic   clk;
   logic   rst;
   pixel_t in_data;
   logic   in_valid;
   pixel_t out_data;
   logic   out_valid;
   logic   out_ready;
   logic   out_first;
   logic   out_last;
   logic   out_frame_end;
   logic   ovf_err;

   pool1_fmap_window_buf dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_first     (out_first),
      .out_last      (out_last),
      .out_frame_end (out_frame_end),
      .ovf_err       (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     ready_mode;
   bit     gap_en;
   pixel_t feed_q[$];
   pixel_t partial[$];
   beat_t  exp_q[$];
   beat_t  got_q[$];
   int     nfull;
   logic   model_ovf;
   int     first_valid_cyc, last_feed_cyc, gap_run, max_gap;
   int     ovf_rise_cyc, ovf_px_cyc, fed_cnt;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic pixel_t pat_pixel(input int i, input int base);
      pixel_t p;
      for (int c = 0; c < int'(CH); c++) p[c*DW +: DW] = DW'(i * 8 + c + base);
      return p;
   endfunction

   function automatic pixel_t rand_pixel();
      return PW'({$urandom, $urandom, $urandom});
   endfunction

   function automatic pixel_t stored(input pixel_t p);
      pixel_t s;
      s = p;
`ifdef POOL1_BUF_RELU_EN
      for (int c = 0; c < int'(CH); c++) if (p[c*DW + DW - 1]) s[c*DW +: DW] = '0;
`endif
      return s;
   endfunction

   function automatic beat_t mk_beat(input pixel_t d, input bit f, input bit l, input bit e);
      return {e, l, f, d};
   endfunction

   // Expand a captured frame into its full tap sequence
   task automatic push_frame();
      for (int oy = 0; oy < NO; oy++)
         for (int ox = 0; ox < NO; ox++)
            for (int ky = 0; ky < NK; ky++)
               for (int kx = 0; kx < NK; kx++) begin
                  bit f, l, e;
                  f = (kx == 0) && (ky == 0);
                  l = (kx == NK - 1) && (ky == NK - 1);
                  e = l && (ox == NO - 1) && (oy == NO - 1);
                  exp_q.push_back(mk_beat(stored(partial[(oy + ky) * NI + ox + kx]), f, l, e));
               end
   endtask

   // Pixel capture model: dropped when two frames are waiting
   task automatic model_write(input pixel_t p);
      if (nfull == 2) begin
         model_ovf = 1'b1;
      end else begin
         partial.push_back(p);
         if (partial.size() == NPX) begin
            push_frame();
            partial.delete();
            nfull++;
         end
      end
   endtask

   task automatic phase_start();
      first_valid_cyc = -1;
      last_feed_cyc   = -1;
      gap_run         = 0;
      max_gap         = 0;
      ovf_rise_cyc    = -1;
      ovf_px_cyc      = -1;
      fed_cnt         = 0;
      got_q.delete();
   endtask

   // One clock: observe outputs, drive inputs for the coming edge, update model
   task automatic cycle();
      beat_t obs;
      @(negedge clk);
      cyc++;
      check("ovf_err", 128'(ovf_err), 128'(model_ovf));
      if (ovf_err && ovf_rise_cyc < 0) ovf_rise_cyc = cyc;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
      obs = {out_frame_end, out_last, out_first, out_data};
      if (out_valid) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         gap_run = 0;
         if (exp_q.size() == 0) begin
            check("spurious_valid", 128'(1), 128'(0));
         end else begin
            check(out_ready ? "beat" : "held_beat", 128'(obs), 128'(exp_q[0]));
            if (out_ready) begin
               if (exp_q[0][BW-1]) nfull--;
               void'(exp_q.pop_front());
               got_q.push_back(obs);
            end
         end
      end else if (first_valid_cyc >= 0 && exp_q.size() > 0) begin
         gap_run++;
         if (gap_run > max_gap) max_gap = gap_run;
      end
      if (feed_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
         in_valid = 1'b1;
         in_data  = feed_q.pop_front();
         fed_cnt++;
         last_feed_cyc = cyc;
         if (fed_cnt == 2 * NPX + 1) ovf_px_cyc = cyc;
         model_write(in_data);
      end else begin
         in_valid = 1'b0;
         in_data  = rand_pixel();
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((feed_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      check("drain_done", 128'(exp_q.size()), 128'(0));
      repeat (8) cycle();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, 128'(out_valid), 128'(0));
      check({tag, "_data"}, 128'(out_data), 128'(0));
      check({tag, "_first"}, 128'(out_first), 128'(0));
      check({tag, "_last"}, 128'(out_last), 128'(0));
      check({tag, "_fend"}, 128'(out_frame_end), 128'(0));
      check({tag, "_ovf"}, 128'(ovf_err), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      ready_mode = 2;
      gap_en     = 1'b0;
      nfull      = 0;
      model_ovf  = 1'b0;
      phase_start();

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      // Single frame, ready held high
      phase_start();
      ready_mode = 0;
      for (int i = 0; i < NPX; i++) feed_q.push_back(pat_pixel(i, 0));
      drain(4000);
      check("single_count", 128'(got_q.size()), 128'(NBT));
      check("first_latency", 128'(first_valid_cyc - last_feed_cyc), 128'(3));
      if (got_q.size() == NBT) begin
         check("beat0", 128'(got_q[0]), 128'(mk_beat(pat_pixel(0, 0), 1, 0, 0)));
         check("beat1", 128'(got_q[1]), 128'(mk_beat(pat_pixel(1, 0), 0, 0, 0)));
         check("beat5", 128'(got_q[5]), 128'(mk_beat(pat_pixel(12, 0), 0, 0, 0)));
         check("beat24", 128'(got_q[24]), 128'(mk_beat(pat_pixel(52, 0), 0, 1, 0)));
         check("beat25", 128'(got_q[25]), 128'(mk_beat(pat_pixel(1, 0), 1, 0, 0)));
         check("beat_end", 128'(got_q[NBT-1]), 128'(mk_beat(pat_pixel(143, 0), 0, 1, 1)));
      end

      // Back-to-back frames
      phase_start();
      for (int i = 0; i < NPX; i++) feed_q.push_back(pat_pixel(i, 16'h200));
      for (int i = 0; i < NPX; i++) feed_q.push_back(pat_pixel(i, 16'h600));
      drain(6000);
      check("b2b_count", 128'(got_q.size()), 128'(2 * NBT));
      check("b2b_gap_le2", 128'(max_gap <= 2), 128'(1));
      check("b2b_ovf", 128'(ovf_err), 128'(0));

      // Random back-pressure and input gaps
      phase_start();
      ready_mode = 1;
      gap_en     = 1'b1;
      for (int i = 0; i < NPX; i++) feed_q.push_back(pat_pixel(i, 0));
      for (int i = 0; i < NPX; i++) feed_q.push_back(rand_pixel());
      drain(20000);
      check("bp_count", 128'(got_q.size()), 128'(2 * NBT));

      // Overflow: three frames while the consumer is stalled
      phase_start();
      ready_mode = 2;
      gap_en     = 1'b0;
      for (int i = 0; i < 3 * NPX; i++) feed_q.push_back(rand_pixel());
      n = 0;
      while (feed_q.size() > 0 && n < 1000) begin
         cycle();
         n++;
      end
      repeat (4) cycle();
      check("ovf_set", 128'(ovf_err), 128'(1));
      check("ovf_rise_timing", 128'(ovf_rise_cyc - ovf_px_cyc), 128'(1));
      ready_mode = 0;
      drain(6000);
      check("ovf_count", 128'(got_q.size()), 128'(2 * NBT));
      check("ovf_sticky", 128'(ovf_err), 128'(1));

      // Reset in the middle of replay
      phase_start();
      for (int i = 0; i < NPX; i++) feed_q.push_back(pat_pixel(i, 16'h40));
      n = 0;
      while (got_q.size() < 700 && n < 5000) begin
         cycle();
         n++;
      end
      check("reached_beat700", 128'(got_q.size()), 128'(700));
      #2 rst = 1'b1;
      #1 check_idle_outputs("midrst");
      exp_q.delete();
      partial.delete();
      feed_q.delete();
      nfull     = 0;
      model_ovf = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      phase_start();
      for (int i = 0; i < NPX; i++) feed_q.push_back(rand_pixel());
      drain(4000);
      check("post_rst_count", 128'(got_q.size()), 128'(NBT));
      check("post_rst_latency", 128'(first_valid_cyc - last_feed_cyc), 128'(3));

`ifdef POOL1_BUF_RELU_EN
      // Negative channels clamp to zero, positive pass through
      phase_start();
      for (int i = 0; i < NPX; i++) begin
         pixel_t p;
         for (int c = 0; c < int'(CH); c++) p[c*DW +: DW] = (i % 2 == 0) ? 16'hFF38 : 16'h00C8;
         feed_q.push_back(p);
      end
      drain(4000);
      if (got_q.size() == NBT) begin
         check("relu_neg", 128'(got_q[0][DW-1:0]), 128'(0));
         check("relu_pos", 128'(got_q[1][DW-1:0]), 128'(16'h00C8));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pool1_fmap_window_buf
